// File: rtl/seven_segment_fun1_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_fun1_if
// Description : Tiny Tapeout user-block bus for the seven_segment_fun1 design.
//               It bundles the design-enable flag, the dedicated input and
//               output bytes and the bidirectional byte (in, out, enable).
//               master : the surrounding harness, which drives ena/ui_in/uio_in
//               slave  : the user block, which drives uo_out/uio_out/uio_oe
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_segment_fun1_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface
`default_nettype wire

// File: rtl/seven_segment_fun1.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_fun1
// Description : Four debounced push-buttons driving one 7-segment display.
//               ui_in[0] increments and ui_in[1] decrements a 4-bit hex count.
//               ui_in[2] toggles the animation mode. ui_in[3] toggles the
//               decimal point.
//               Optional feature macro: SEG_ANIM_EN. When it is defined, the
//               mode button and the rotating-segment animation are built.
//               When it is undefined, the mode button is debounced but has no
//               effect, and the display always shows the count.
// Ports       : clk     - system clock
//               rst_n   - asynchronous reset, active HIGH despite its name
//               bus     - slave side of seven_segment_fun1_if:
//                         ui_in[3:0] buttons, uo_out = {dp, g..a},
//                         uio_out and uio_oe held at 8'h00
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_fun1 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ANIM_CYCLES     = 2000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_segment_fun1_if.slave  bus
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // One-cycle press strobes, one per button, in the cycle the stable level
  // goes from 0 to 1.
  logic [3:0] w_press;

  // --------------------------------------------------------------------------
  // Per-button synchroniser and debouncer
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [1:0]     sync_q;
    logic           stable_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        sync_q   <= 2'b00;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync_q <= {sync_q[0], bus.ui_in[gi]};
        if (sync_q[1] == stable_q) begin
          // A level that bounces back restarts the qualification window.
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          stable_q <= sync_q[1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    // The release edge is qualified the same way but produces no strobe.
    assign w_press[gi] = (sync_q[1] != stable_q) && (cnt_q == DB_LAST) && sync_q[1];
  end

  // --------------------------------------------------------------------------
  // Count and decimal point
  // --------------------------------------------------------------------------
  logic [3:0] count_q;
  logic       dp_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q <= 4'h0;
      dp_q    <= 1'b0;
    end else begin
      // Simultaneous inc and dec cancel each other out.
      case (w_press[1:0])
        2'b01:   count_q <= count_q + 4'h1;
        2'b10:   count_q <= count_q - 4'h1;
        default: count_q <= count_q;
      endcase
      if (w_press[3]) begin
        dp_q <= ~dp_q;
      end
    end
  end

  // Hex digit decoder, with segment a in bit 0.
  logic [6:0] w_hex;
  always_comb begin
    w_hex = 7'h00;
    case (count_q)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
  end

  logic [6:0] w_seg_d;

`ifdef SEG_ANIM_EN
  // --------------------------------------------------------------------------
  // Display mode FSM and animation stepper
  // --------------------------------------------------------------------------
  localparam int AW = (ANIM_CYCLES > 1) ? $clog2(ANIM_CYCLES) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_CYCLES - 1);

  typedef enum logic [0:0] {
    MODE_COUNT = 1'b0,
    MODE_ANIM  = 1'b1
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [2:0]    anim_idx_q;
  logic [AW-1:0] anim_tmr_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mode_q <= MODE_COUNT;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (w_press[2]) begin
      case (mode_q)
        MODE_COUNT: mode_d = MODE_ANIM;
        MODE_ANIM:  mode_d = MODE_COUNT;
        default:    mode_d = MODE_COUNT;
      endcase
    end
  end

  // The stepper is held cleared in COUNT mode, so each entry into ANIM starts
  // at segment a with a fresh step timer.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      anim_idx_q <= 3'd0;
      anim_tmr_q <= '0;
    end else if (mode_q != MODE_ANIM) begin
      anim_idx_q <= 3'd0;
      anim_tmr_q <= '0;
    end else if (anim_tmr_q == ANIM_LAST) begin
      anim_tmr_q <= '0;
      anim_idx_q <= (anim_idx_q == 3'd5) ? 3'd0 : anim_idx_q + 3'd1;
    end else begin
      anim_tmr_q <= anim_tmr_q + 1'b1;
    end
  end

  assign w_seg_d = (mode_q == MODE_ANIM) ? (7'h01 << anim_idx_q) : w_hex;
`else
  assign w_seg_d = w_hex;
  wire w_unused_mode = w_press[2];
`endif

  // --------------------------------------------------------------------------
  // Registered display output
  // --------------------------------------------------------------------------
  logic [7:0] uo_out_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      uo_out_q <= 8'h3F;
    end else begin
      uo_out_q <= {dp_q, w_seg_d};
    end
  end

  assign bus.uo_out  = uo_out_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  wire w_unused = &{1'b0, bus.ena, bus.uio_in, bus.ui_in[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_fun1.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_fun1
// Description : Testbench for seven_segment_fun1. It uses short debounce and
//               animation periods, a hex-count/decimal-point reference model,
//               directed steps and randomized button masks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_fun1;
  localparam int DB = 10;
  localparam int AN = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seven_segment_fun1_if bus ();

  seven_segment_fun1 #(
    .DEBOUNCE_CYCLES (DB),
    .ANIM_CYCLES     (AN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: hex count and decimal-point state.
  int         m_count;
  logic       m_dp;
  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7:0] exp_disp();
    return {m_dp, HEX[m_count]};
  endfunction

  task automatic apply_model(input logic [3:0] m);
    if (m[0] && !m[1]) m_count = (m_count + 1) % 16;
    if (m[1] && !m[0]) m_count = (m_count + 15) % 16;
    if (m[3]) m_dp = ~m_dp;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    bus.ui_in = 8'h00;
    cyc(5);
    chk8("reset_uo_out_during", bus.uo_out, 8'h3F);
    rst_n = 1'b0;
    m_count = 0;
    m_dp = 1'b0;
    cyc(2);
    chk8("reset_uo_out_after", bus.uo_out, 8'h3F);
  endtask

  // Clean press: hold well past the debounce window, then release just as long.
  task automatic press(input logic [3:0] m);
    bus.ui_in[3:0] = m;
    cyc(30);
    bus.ui_in[3:0] = 4'h0;
    cyc(30);
    apply_model(m);
  endtask

  initial begin
    int changes;
    logic [7:0] prev;
    logic [3:0] mask;

    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    // Reset and constant outputs.
    do_reset();
    chk8("uio_out", bus.uio_out, 8'h00);
    chk8("uio_oe", bus.uio_oe, 8'h00);

    // A glitch shorter than the debounce window is ignored.
    bus.ui_in[0] = 1'b1;
    cyc(5);
    bus.ui_in[0] = 1'b0;
    cyc(20);
    chk8("short_pulse", bus.uo_out, 8'h3F);

    // The ignored inputs have no effect.
    bus.ui_in[7:4] = 4'hF;
    bus.uio_in = 8'hA5;
    bus.ena = 1'b0;
    cyc(30);
    bus.ui_in[7:4] = 4'h0;
    bus.uio_in = 8'h00;
    bus.ena = 1'b1;
    chk8("ignored_inputs", bus.uo_out, 8'h3F);

    // Holding a button gives exactly one event.
    bus.ui_in[0] = 1'b1;
    changes = 0;
    prev = bus.uo_out;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.uo_out !== prev) changes++;
      prev = bus.uo_out;
    end
    chki("hold_change_count", changes, 1);
    chk8("hold_value", bus.uo_out, 8'h06);
    bus.ui_in[0] = 1'b0;
    cyc(30);
    chk8("after_release", bus.uo_out, 8'h06);

    // Reset in the middle of debouncing discards the partial count.
    do_reset();
    bus.ui_in[0] = 1'b1;
    cyc(6);
    rst_n = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    cyc(6);
    bus.ui_in[0] = 1'b0;
    cyc(20);
    chk8("reset_mid_debounce", bus.uo_out, 8'h3F);

    // Decrementing from 0 wraps to F.
    do_reset();
    press(4'b0010);
    chk8("dec_wrap_F", bus.uo_out, 8'h71);

    // Sixteen increments walk the digit through 1..F and back to 0.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      press(4'b0001);
      chk8($sformatf("inc_step_%0d", i), bus.uo_out, exp_disp());
    end
    chk8("inc_wrap_0", bus.uo_out, 8'h3F);

    // The decimal point toggles on and off without touching the digit.
    press(4'b0001);
    press(4'b1000);
    chk8("dp_on", bus.uo_out, 8'h86);
    press(4'b1000);
    chk8("dp_off", bus.uo_out, 8'h06);

    // Simultaneous inc and dec leave the count unchanged.
    press(4'b0011);
    chk8("inc_dec_same_cycle", bus.uo_out, 8'h06);

`ifdef SEG_ANIM_EN
    // Animation: a single segment steps every AN cycles, and the dp still shows.
    press(4'b1000);
    bus.ui_in[2] = 1'b1;
    changes = 0;
    while (bus.uo_out[6:0] !== 7'h01 && changes < 40) begin
      cyc(1);
      changes++;
    end
    chk8("anim_start", bus.uo_out, {m_dp, 7'h01});
    for (int k = 1; k <= 6; k++) begin
      int n;
      logic [6:0] want;
      want = 7'h01 << (k % 6);
      prev = bus.uo_out;
      n = 0;
      while (bus.uo_out === prev && n < 30) begin
        cyc(1);
        n++;
      end
      chk8($sformatf("anim_step_%0d", k), bus.uo_out, {m_dp, want});
      chki($sformatf("anim_period_%0d", k), n, AN);
    end
    bus.ui_in[2] = 1'b0;
    cyc(30);
    press(4'b0100);
    chk8("anim_exit", bus.uo_out, exp_disp());
`else
    // Without animation support, the mode button has no visible effect.
    press(4'b0100);
    chk8("mode_ignored", bus.uo_out, exp_disp());
`endif

    // Randomized button combinations checked against the model.
    for (int i = 0; i < 24; i++) begin
      mask = 4'($urandom_range(1, 15));
`ifdef SEG_ANIM_EN
      mask[2] = 1'b0;
      if (mask == 4'h0) mask = 4'b0001;
`endif
      press(mask);
      chk8($sformatf("rand_%0d_m%h", i, mask), bus.uo_out, exp_disp());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
